// File: rtl/avalon_st_rr_arbiter_128.sv
// Round-robin arbiter sharing one 128-bit Avalon-ST stream among NUM_IN requesters.
// Each grant is held for BURST_BEATS accepted beats so every 256-bit adapter word has a single source.
module avalon_st_rr_arbiter_128 #(
    parameter int NUM_IN      = 4,
    parameter int BURST_BEATS = 16,
    parameter int ID_W        = 2,
    parameter int CNT_W       = 8
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic [NUM_IN*128-1:0]   st_in_data_i,
    input  logic [NUM_IN-1:0]       st_in_valid_i,
    output logic [NUM_IN-1:0]       st_in_ready_o,
    output logic [127:0]            st_out_data_o,
    output logic                    st_out_valid_o,
    input  logic                    st_out_ready_i,
    output logic [ID_W-1:0]         st_out_channel_o,
    output logic                    busy_o,
    output logic                    burst_done_o
);

    if ((BURST_BEATS % 2) != 0 || BURST_BEATS < 2) begin : g_bad_burst
        $error("BURST_BEATS must be even and >= 2");
    end
    if (NUM_IN > (1 << ID_W) || NUM_IN < 2) begin : g_bad_id_w
        $error("NUM_IN must be 2..2**ID_W");
    end
    if ((1 << CNT_W) <= BURST_BEATS) begin : g_bad_cnt_w
        $error("CNT_W too narrow for BURST_BEATS");
    end

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic              burst_done_q, burst_done_d;

    logic [ID_W-1:0]   pick;
    logic [127:0]      sel_data;
    logic              sel_valid;
    logic              accept;
    logic              last_beat;
    int unsigned       idx;

    // Walk offsets from farthest to nearest so the requester closest to rr_ptr wins.
    always_comb begin
        pick = '0;
        idx  = 0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr_q) + k) % NUM_IN;
            if (st_in_valid_i[idx]) begin
                pick = ID_W'(idx);
            end
        end
    end

    always_comb begin
        sel_data      = '0;
        sel_valid     = 1'b0;
        st_in_ready_o = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (state_q == XFER && grant_q == ID_W'(i)) begin
                sel_data         = st_in_data_i[i*128 +: 128];
                sel_valid        = st_in_valid_i[i];
                st_in_ready_o[i] = st_out_ready_i;
            end
        end
    end

    assign accept    = sel_valid && st_out_ready_i;
    assign last_beat = accept && (beat_cnt_q == CNT_W'(BURST_BEATS - 1));

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        beat_cnt_d   = beat_cnt_q;
        burst_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (|st_in_valid_i) begin
                    grant_d    = pick;
                    beat_cnt_d = '0;
                    state_d    = XFER;
                end
            end
            XFER: begin
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
                if (last_beat) begin
                    state_d      = IDLE;
                    beat_cnt_d   = '0;
                    burst_done_d = 1'b1;
                    rr_ptr_d     = (grant_q == ID_W'(NUM_IN - 1)) ? '0 : grant_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            rr_ptr_q     <= '0;
            beat_cnt_q   <= '0;
            burst_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_ptr_q     <= rr_ptr_d;
            beat_cnt_q   <= beat_cnt_d;
            burst_done_q <= burst_done_d;
        end
    end

    assign st_out_data_o    = sel_data;
    assign st_out_valid_o   = sel_valid;
    assign st_out_channel_o = (state_q == XFER) ? grant_q : '0;
    assign busy_o           = (state_q == XFER);
    assign burst_done_o     = burst_done_q;

endmodule

// File: tb/tb_avalon_st_rr_arbiter_128.sv
// Directed and random stimulus against a burst-level reference model of the round-robin arbiter.
module tb_avalon_st_rr_arbiter_128;
    localparam int N  = 4;
    localparam int BB = 4;

    logic             clk;
    logic             rst;
    logic [N*128-1:0] in_data;
    logic [N-1:0]     in_valid;
    logic [N-1:0]     in_ready;
    logic [127:0]     out_data;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       out_ch;
    logic             busy;
    logic             done;

    avalon_st_rr_arbiter_128 #(
        .NUM_IN(N), .BURST_BEATS(BB), .ID_W(2), .CNT_W(8)
    ) dut (
        .clock_i          (clk),
        .reset_i          (rst),
        .st_in_data_i     (in_data),
        .st_in_valid_i    (in_valid),
        .st_in_ready_o    (in_ready),
        .st_out_data_o    (out_data),
        .st_out_valid_o   (out_valid),
        .st_out_ready_i   (out_ready),
        .st_out_channel_o (out_ch),
        .busy_o           (busy),
        .burst_done_o     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: who owns the stream, beats taken so far, next start point, done pulse.
    int           m_owner = -1;
    int           m_cnt   = 0;
    int           m_ptr   = 0;
    bit           m_done  = 1'b0;
    logic [127:0] data_q [N];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [N-1:0] v, input logic r);
        logic [127:0] e_data;
        logic         e_valid;
        logic [N-1:0] e_ready;
        logic [1:0]   e_ch;
        logic         e_busy;
        bit           found;
        in_valid  = v;
        out_ready = r;
        for (int i = 0; i < N; i++) in_data[i*128 +: 128] = data_q[i];
        #1;
        if (m_owner < 0) begin
            e_data = '0; e_valid = 1'b0; e_ready = '0; e_ch = '0; e_busy = 1'b0;
        end else begin
            e_data  = data_q[m_owner];
            e_valid = v[m_owner];
            e_ready = '0;
            e_ready[m_owner] = r;
            e_ch    = 2'(m_owner);
            e_busy  = 1'b1;
        end
        chk("out_data", out_data, e_data);
        chk("out_valid", 128'(out_valid), 128'(e_valid));
        chk("in_ready", 128'(in_ready), 128'(e_ready));
        chk("channel", 128'(out_ch), 128'(e_ch));
        chk("busy", 128'(busy), 128'(e_busy));
        chk("burst_done", 128'(done), 128'(m_done));
        @(posedge clk);
        m_done = 1'b0;
        if (m_owner < 0) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (!found && v[(m_ptr + k) % N]) begin
                    m_owner = (m_ptr + k) % N;
                    found   = 1'b1;
                end
            end
            m_cnt = 0;
        end else if (v[m_owner] && r) begin
            data_q[m_owner] = data_q[m_owner] + 1;
            m_cnt++;
            if (m_cnt == BB) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_cnt   = 0;
                m_done  = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_valid", 128'(out_valid), 128'd0);
        chk("rst_ready", 128'(in_ready), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_channel", 128'(out_ch), 128'd0);
        chk("rst_data", out_data, 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        m_owner = -1; m_cnt = 0; m_ptr = 0; m_done = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = '0;
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) data_q[i] = (128'(i + 1) << 64);
        for (int i = 0; i < N; i++) in_data[i*128 +: 128] = data_q[i];
        @(negedge clk);
        do_reset();
        step(4'b0000, 1'b1);

        // Single requester 2.
        for (int c = 0; c < 7; c++) step(4'b0100, 1'b1);

        // All valid from a fresh pointer: order 0,1,2,3,0.
        do_reset();
        for (int c = 0; c < 25; c++) step(4'b1111, 1'b1);
        for (int c = 0; c < 6; c++) step(4'b0000, 1'b1);

        // Backpressure on requester 1, data A0..A3.
        data_q[1] = 128'hA0;
        for (int c = 0; c < 11; c++) step(4'b0010, 1'(c % 2 == 1));
        step(4'b0000, 1'b1);

        // Valid gap on requester 0 while requester 3 waits.
        do_reset();
        for (int c = 0; c < 3; c++) step(4'b1001, 1'b1);
        for (int c = 0; c < 3; c++) step(4'b1000, 1'b1);
        for (int c = 0; c < 10; c++) step(4'b1001, 1'b1);

        // Reset mid-burst, then requesters 1 and 3.
        do_reset();
        for (int c = 0; c < 3; c++) step(4'b1010, 1'b1);
        do_reset();
        for (int c = 0; c < 6; c++) step(4'b1010, 1'b1);

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            step(($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/avalon_st_rr_arbiter_128.md
Name: avalon_st_rr_arbiter_128

Overview:
- Round-robin arbiter sharing one 128-bit Avalon-ST stream, which feeds the 128-to-256 width adapter, among NUM_IN 128-bit requester streams.
- Grant is held for a fixed burst of BURST_BEATS accepted beats. Because the burst length is even, every 256-bit adapter word carries data from a single requester.
- Emits the granted channel ID alongside the data so downstream logic can tag each 256-bit word.

Parameters:
- NUM_IN, 4, number of requester streams (2..8).
- BURST_BEATS, 16, 128-bit beats transferred per grant; must be even and >= 2.
- ID_W, 2, width of the channel ID; must satisfy 2**ID_W >= NUM_IN.
- CNT_W, 8, beat counter width; must satisfy 2**CNT_W > BURST_BEATS.

Ports:
- clock  in  1  clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- st_in_data  in  NUM_IN*128  requester data; requester i occupies bits [i*128 +: 128].
- st_in_valid  in  NUM_IN  per-requester valid.
- st_in_ready  out  NUM_IN  per-requester ready.
- st_out_data  out  128  data to the width adapter.
- st_out_valid  out  1  output valid.
- st_out_ready  in  1  adapter ready.
- st_out_channel  out  ID_W  ID of the granted requester.
- busy  out  1  high while a grant is held (XFER state).
- burst_done  out  1  one-cycle pulse registered on the cycle after the final beat of a burst.

Behaviour:
- States: IDLE and XFER. Registers: state, grant (ID_W), rr_ptr (ID_W), beat_cnt (CNT_W), burst_done.
- Reset values (asynchronous): state=IDLE, grant=0, rr_ptr=0, beat_cnt=0, burst_done=0. While reset is asserted or state is IDLE: st_out_valid=0, st_in_ready=all 0, busy=0, st_out_channel=0, st_out_data=0.
- IDLE:
  - If any st_in_valid bit is set, set grant to the first index i, searching rr_ptr, rr_ptr+1, ... modulo NUM_IN, with st_in_valid[i]=1.
  - Also set beat_cnt=0 and go to XFER on the next edge. Arbitration costs one cycle; no data moves in IDLE.
- XFER (combinational datapath, zero added latency):
  - st_out_data = slice[grant]; st_out_valid = st_in_valid[grant].
  - st_in_ready[grant] = st_out_ready; all other st_in_ready bits = 0.
  - st_out_channel = grant; busy = 1.
- A beat is accepted when st_out_valid && st_out_ready; beat_cnt increments per accepted beat.
- Grant is held through valid gaps and backpressure. There is no timeout and no preemption.
- On the accepted beat where beat_cnt == BURST_BEATS-1:
  - Next state is IDLE, rr_ptr = grant+1 (wrapping to 0 at NUM_IN), beat_cnt = 0.
  - burst_done=1 for exactly the following cycle.
- Back-to-back bursts: minimum gap is one IDLE cycle between bursts. The same requester may be re-granted only if no other requester is valid in that IDLE cycle.
- Requesters whose st_in_valid is low in the IDLE arbitration cycle are skipped. Requester data must follow Avalon-ST rules: held stable while valid and not ready.
- Reset mid-burst returns immediately to IDLE with rr_ptr=0. Any partial 256-bit word in the adapter is discarded by the shared reset. The beat count in flight is lost; no recovery is required.
- Parameter violations (odd BURST_BEATS, NUM_IN > 2**ID_W) are flagged by a simulation-time error at elaboration.

Test Plan:
- Single requester: only requester 2 valid, BURST_BEATS=4, st_out_ready=1 -> one IDLE cycle, then 4 consecutive beats with channel=2; burst_done pulse one cycle later; rr_ptr=3.
- All four requesters valid continuously, ready=1, BURST_BEATS=4 -> grant order 0,1,2,3,0; 4 beats each; exactly one IDLE cycle between bursts; no beat is ever presented with a mismatched channel.
- Backpressure: requester 1 granted, st_out_ready toggling 1,0,1,0 -> st_in_ready[1] mirrors st_out_ready; burst completes after exactly 4 accepted beats (8 cycles); data values 0xA0..0xA3 arrive in order, none duplicated.
- Valid gap mid-burst: requester 0 drops valid for 3 cycles after beat 1 while requester 3 is valid -> grant stays 0; requester 3 sees ready=0 until the burst ends, then wins.
- Reset after beat 2 of a 4-beat burst -> all outputs read 0 in the same cycle; after release, with requesters 1 and 3 valid, requester 1 is granted (rr_ptr=0).
- End to end with the adapter: NUM_IN=2, BURST_BEATS=2, alternating requesters -> each 256-bit output word has both halves from one requester, ordered upper half = first beat, lower half = second beat.
